// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 frame driver.
// Optional brightness scaling is enabled by defining WS2812_BRIGHTNESS_EN.
package ws2812_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SEND, LATCH} state_t;

  localparam int BITS_PER_LED = 24;

  // RAM word is 0x00RRGGBB; the strip expects G, then R, then B.
  function automatic logic [23:0] grb_reorder(input logic [31:0] word);
    return {word[15:8], word[23:16], word[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// WS2812 bit serialiser: 24-bit shift register plus a per-bit down-counter.
// Loading on the final cycle of a word continues the stream with no gap.
module ws2812_bit_tx
  import ws2812_pkg::*;
#(
  parameter int BIT_CYC = 63,
  parameter int T0H_CYC = 20,
  parameter int T1H_CYC = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [23:0] data,
  output logic        dout,
  output logic        last_bit_first_cycle,
  output logic        word_done
);

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_TOP  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] EDGE_0   = CW'(BIT_CYC - T0H_CYC);
  localparam logic [CW-1:0] EDGE_1   = CW'(BIT_CYC - T1H_CYC);
  localparam logic [4:0]    LAST_BIT = 5'(BITS_PER_LED - 1);

  logic [23:0]   shreg;
  logic [CW-1:0] cnt;
  logic [4:0]    bit_idx;
  logic          active;

  assign last_bit_first_cycle = active && (bit_idx == LAST_BIT) && (cnt == CNT_TOP);
  assign word_done            = active && (bit_idx == LAST_BIT) && (cnt == '0);

  // dout is registered: each update computes the level for the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      active  <= 1'b0;
      dout    <= 1'b0;
    end else if (load) begin
      shreg   <= data;
      cnt     <= CNT_TOP;
      bit_idx <= '0;
      active  <= 1'b1;
      dout    <= 1'b1;
    end else if (active) begin
      if (cnt == '0) begin
        if (bit_idx == LAST_BIT) begin
          active <= 1'b0;
          dout   <= 1'b0;
        end else begin
          shreg   <= {shreg[22:0], 1'b0};
          bit_idx <= bit_idx + 5'd1;
          cnt     <= CNT_TOP;
          dout    <= 1'b1;
        end
      end else begin
        cnt  <= cnt - 1'b1;
        dout <= (cnt > (shreg[23] ? EDGE_1 : EDGE_0));
      end
    end
  end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Reads NUM_LEDS colour words from RAM port 2 and streams them to a WS2812 strip.
// Define WS2812_BRIGHTNESS_EN to add a per-frame brightness input.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | read of LED 0 issued to RAM
// CAPTURE | LED 0 word arrives, loaded into serialiser
// SEND    | bits on the wire; next word prefetched during bit 23
// LATCH   | strip latch low period, done on its final cycle
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS  = 64,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 13,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int LATCH_CYC = 15000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]        brightness,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [31:0]       mem_readdata,
  output logic              led_dout
);

  if (NUM_LEDS < 1 || BASE_ADDR + NUM_LEDS > 8192) begin : g_bad_range
    $error("ws2812_frame_driver: LED range exceeds RAM");
  end
  if (BIT_CYC <= T1H_CYC) begin : g_bad_timing
    $error("ws2812_frame_driver: BIT_CYC must exceed T1H_CYC");
  end

  localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
  localparam logic [LW-1:0]     LATCH_TOP = LW'(LATCH_CYC - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_LEDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [LW-1:0]     latch_cnt;
  logic [23:0]       shadow;
  logic [23:0]       rd_grb;
  logic [23:0]       tx_data;
  logic              prefetch, prefetch_q;
  logic              tx_load, tx_last_first, tx_word_done;

  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  assign prefetch       = (state == SEND) && tx_last_first && (idx != LAST_IDX);
  assign mem_chipselect = (state == FETCH) || prefetch;
  assign mem_address    = ADDR_W'(BASE_ADDR) + idx + {{(ADDR_W-1){1'b0}}, prefetch};

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_q;

  function automatic logic [7:0] dim(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = {8'd0, c} * ({8'd0, b} + 16'd1);
    return p[15:8];
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   bright_q <= 8'hFF;
    else if (state == IDLE && start) bright_q <= brightness;
  end

  assign rd_grb = {dim(grb_reorder(mem_readdata)[23:16], bright_q),
                   dim(grb_reorder(mem_readdata)[15:8],  bright_q),
                   dim(grb_reorder(mem_readdata)[7:0],   bright_q)};
`else
  assign rd_grb = grb_reorder(mem_readdata);
`endif

  assign tx_load = (state == CAPTURE) ||
                   ((state == SEND) && tx_word_done && (idx != LAST_IDX));
  assign tx_data = (state == CAPTURE) ? rd_grb : shadow;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      latch_cnt  <= '0;
      shadow     <= '0;
      prefetch_q <= 1'b0;
    end else begin
      prefetch_q <= prefetch;
      if (prefetch_q) shadow <= rd_grb;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH:   state <= CAPTURE;
        CAPTURE: state <= SEND;
        SEND: begin
          if (tx_word_done) begin
            if (idx == LAST_IDX) begin
              state     <= LATCH;
              latch_cnt <= LATCH_TOP;
              done      <= (LATCH_TOP == '0);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        LATCH: begin
          if (latch_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
          end else begin
            latch_cnt <= latch_cnt - 1'b1;
            done      <= (latch_cnt == LW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ws2812_bit_tx #(
    .BIT_CYC(BIT_CYC),
    .T0H_CYC(T0H_CYC),
    .T1H_CYC(T1H_CYC)
  ) u_bit_tx (
    .clk                  (clk),
    .reset_n              (reset_n),
    .load                 (tx_load),
    .data                 (tx_data),
    .dout                 (led_dout),
    .last_bit_first_cycle (tx_last_first),
    .word_done            (tx_word_done)
  );

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Randomised self-checking bench for ws2812_frame_driver against a waveform-level model.
// Brightness cases are included when WS2812_BRIGHTNESS_EN is defined.
module tb_ws2812_frame_driver;

  localparam int BIT_CYC = 63;
  localparam int T0H     = 20;
  localparam int T1H     = 40;
  localparam int N       = 3;
  localparam int BASE    = 100;
  localparam int LATCH   = 500;
  localparam int LATCH1  = 15000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, start1 = 1'b0;
  logic        busy, done, cs, wr, clken, dout;
  logic        busy1, done1, cs1, wr1, clken1, dout1;
  logic [12:0] addr, addr1;
  logic [3:0]  be, be1;
  logic [31:0] rdata, rdata1;
  logic [7:0]  bright = 8'hFF;
  logic [7:0]  bright1 = 8'hFF;

  logic [31:0] mem [0:8191];
  logic [12:0] addr_q = '0, addr_q1 = '0;
  logic        cs_q = 1'b0, cs_q1 = 1'b0;

  // RAM port 2: registered address, unregistered data; junk when nothing was selected.
  always @(posedge clk) begin
    addr_q  <= addr;  cs_q  <= cs;
    addr_q1 <= addr1; cs_q1 <= cs1;
  end
  assign rdata  = cs_q  ? mem[addr_q]  : 32'hA5A5_5A5A;
  assign rdata1 = cs_q1 ? mem[addr_q1] : 32'h5A5A_A5A5;

  ws2812_frame_driver #(.NUM_LEDS(N), .BASE_ADDR(BASE), .LATCH_CYC(LATCH)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(bright),
`endif
    .busy(busy), .done(done), .mem_address(addr), .mem_chipselect(cs),
    .mem_write(wr), .mem_byteenable(be), .mem_clken(clken),
    .mem_readdata(rdata), .led_dout(dout)
  );

  ws2812_frame_driver #(.NUM_LEDS(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1),
`ifdef WS2812_BRIGHTNESS_EN
    .brightness(bright1),
`endif
    .busy(busy1), .done(done1), .mem_address(addr1), .mem_chipselect(cs1),
    .mem_write(wr1), .mem_byteenable(be1), .mem_clken(clken1),
    .mem_readdata(rdata1), .led_dout(dout1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic        got_wave[$];
  int          cs_pos[$];
  int          cs_adr[$];
  int          done_at, done_cnt;
  logic [31:0] frame_words[$];
  logic [23:0] dec_words[$];

  function automatic logic [7:0] sc(input logic [7:0] c, input int br);
    int v;
    v = int'(c) * (br + 1) / 256;
    return 8'(v);
  endfunction

  task automatic snapshot(input int base, input int n);
    frame_words.delete();
    for (int k = 0; k < n; k++) frame_words.push_back(mem[base + k]);
  endtask

  task automatic launch(input bit sel);
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start1 = 1'b0;
    check("busy_rise", sel ? busy1 : busy, 1'b1);
  endtask

  // Samples one frame at negedges until busy falls; optionally pokes start while busy.
  task automatic collect(input bit sel, input int inj_mid, input bit inj_done, input int max_cyc);
    int i;
    i = 0;
    got_wave.delete(); cs_pos.delete(); cs_adr.delete();
    done_at = -1; done_cnt = 0;
    while ((sel ? busy1 : busy) === 1'b1 && i < max_cyc) begin
      if (!sel) start = 1'b0;
      got_wave.push_back(sel ? dout1 : dout);
      if ((sel ? cs1 : cs) === 1'b1) begin
        cs_pos.push_back(i);
        cs_adr.push_back(int'(sel ? addr1 : addr));
      end
      if ((sel ? done1 : done) === 1'b1) begin
        done_cnt++;
        done_at = i;
        if (inj_done && !sel) start = 1'b1;
      end
      if (i == inj_mid && !sel) start = 1'b1;
      @(negedge clk);
      i++;
    end
    check("frame_end", sel ? busy1 : busy, 1'b0);
  endtask

  task automatic verify(input string tag, input int n, input int base, input int latch, input int br);
    logic        exp_wave[$];
    logic [23:0] eg[$];
    logic [23:0] dec;
    logic [31:0] w;
    int          mism, th, highs, ix, epos;
    mism = 0;
    for (int k = 0; k < n; k++) begin
      w = frame_words[k];
      eg.push_back({sc(w[15:8], br), sc(w[23:16], br), sc(w[7:0], br)});
    end
    exp_wave.push_back(1'b0);
    exp_wave.push_back(1'b0);
    for (int k = 0; k < n; k++)
      for (int b = 23; b >= 0; b--) begin
        th = eg[k][b] ? T1H : T0H;
        for (int c = 0; c < BIT_CYC; c++) exp_wave.push_back(c < th);
      end
    for (int c = 0; c < latch; c++) exp_wave.push_back(1'b0);

    check({tag, "_busy_len"}, got_wave.size(), exp_wave.size());
    for (int i = 0; i < got_wave.size() && i < exp_wave.size(); i++)
      if (got_wave[i] !== exp_wave[i]) mism++;
    check({tag, "_wave_mismatch_samples"}, mism, 0);

    dec_words.delete();
    for (int k = 0; k < n; k++) begin
      dec = '0;
      for (int b = 23; b >= 0; b--) begin
        highs = 0;
        for (int c = 0; c < BIT_CYC; c++) begin
          ix = 2 + (k * 24 + (23 - b)) * BIT_CYC + c;
          if (ix < got_wave.size() && got_wave[ix] === 1'b1) highs++;
        end
        dec[b] = (highs > (T0H + T1H) / 2);
      end
      dec_words.push_back(dec);
      check({tag, "_led_grb"}, dec, eg[k]);
    end

    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_pos"}, done_at, exp_wave.size() - 1);
    check({tag, "_cs_cnt"}, cs_pos.size(), n);
    for (int j = 0; j < cs_pos.size() && j < n; j++) begin
      epos = (j == 0) ? 0 : 2 + (j - 1) * 24 * BIT_CYC + 23 * BIT_CYC;
      check({tag, "_cs_pos"}, cs_pos[j], epos);
      check({tag, "_cs_addr"}, cs_adr[j], base + j);
    end
  endtask

  task automatic rand_words();
    for (int k = 0; k < N; k++) mem[BASE + k] = $urandom;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog busy=%0b expired", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    int i;
    for (int a = 0; a < 8192; a++) mem[a] = $urandom;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_cs", cs, 1'b0);
    check("rst_addr", addr, 13'(BASE));
    check("rst_addr1", addr1, 13'd0);
    check("const_write", wr, 1'b0);
    check("const_be", be, 4'hF);
    check("const_clken", clken, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // single LED, default timing and full latch period
    mem[0] = 32'h00FF_0000;
    snapshot(0, 1);
    launch(1'b1);
    collect(1'b1, -1, 1'b0, 2 + 24 * BIT_CYC + LATCH1 + 50);
    verify("one_led", 1, 0, LATCH1, 255);
    check("one_led_busy_exact", got_wave.size(), 2 + 24 * 63 + 15000);
    @(negedge clk);

    repeat (3) begin
      rand_words();
      snapshot(BASE, N);
      launch(1'b0);
      collect(1'b0, -1, 1'b0, 6000);
      verify("rand", N, BASE, LATCH, 255);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    // seamless LED boundary
    mem[BASE] = 32'h0000_0001;
    mem[BASE + 1] = 32'h0080_0000;
    mem[BASE + 2] = $urandom;
    snapshot(BASE, N);
    launch(1'b0);
    collect(1'b0, -1, 1'b0, 6000);
    verify("seam", N, BASE, LATCH, 255);
    check("seam_last_bit_high", got_wave[2 + 23 * BIT_CYC + T1H - 1], 1'b1);
    check("seam_gap_low", got_wave[2 + 24 * BIT_CYC - 1], 1'b0);
    check("seam_rise", got_wave[2 + 24 * BIT_CYC], 1'b1);
    @(negedge clk);

    // start mid-SEND and on the done cycle are ignored; the next cycle starts a frame
    rand_words();
    snapshot(BASE, N);
    launch(1'b0);
    collect(1'b0, 700, 1'b1, 6000);
    verify("busy_start", N, BASE, LATCH, 255);
    check("done_start_ignored", busy, 1'b0);
    rand_words();
    snapshot(BASE, N);
    launch(1'b0);
    collect(1'b0, -1, 1'b0, 6000);
    verify("b2b", N, BASE, LATCH, 255);
    @(negedge clk);

    // reset during a high phase
    rand_words();
    launch(1'b0);
    i = 0;
    while (!(i >= 200 && dout === 1'b1) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("rst_hit_high", dout, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dout", dout, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_cs", cs, 1'b0);
    check("async_rst_addr", addr, 13'(BASE));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", busy, 1'b0);
    rand_words();
    snapshot(BASE, N);
    launch(1'b0);
    collect(1'b0, -1, 1'b0, 6000);
    verify("after_rst", N, BASE, LATCH, 255);
    @(negedge clk);

`ifdef WS2812_BRIGHTNESS_EN
    rand_words();
    mem[BASE] = 32'h00C8_FF10;
    snapshot(BASE, N);
    bright = 8'd127;
    launch(1'b0);
    bright = 8'd3;
    collect(1'b0, -1, 1'b0, 6000);
    verify("bright127", N, BASE, LATCH, 127);
    check("bright127_led0", dec_words[0], 24'h7F6408);
    @(negedge clk);
    rand_words();
    snapshot(BASE, N);
    bright = 8'd0;
    launch(1'b0);
    collect(1'b0, -1, 1'b0, 6000);
    verify("bright0", N, BASE, LATCH, 0);
    check("bright0_led1", dec_words[1], 24'h000000);
    bright = 8'hFF;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_driver.md
Name: ws2812_frame_driver

Overview:
- Downstream consumer of the second port (s2) of the on-chip dual-port colour RAM.
- On a start pulse, reads NUM_LEDS consecutive 32-bit colour words starting at BASE_ADDR and serialises them onto a WS2812-style single-wire LED strip, giving the Ambilight output.
- Ends each frame with the strip latch/reset low period.
- The HPS/Nios side writes colours through port s1; this block only reads.

Parameters:
- NUM_LEDS, 64, LEDs per frame; range 1..8192.
- BASE_ADDR, 0, word address of LED 0; elaboration error if BASE_ADDR+NUM_LEDS > 8192.
- ADDR_W, 13, RAM word-address width.
- T0H_CYC, 20, high cycles for a '0' bit (0.4 us at 50 MHz).
- T1H_CYC, 40, high cycles for a '1' bit (0.8 us).
- BIT_CYC, 63, total cycles per bit; must be greater than T1H_CYC.
- LATCH_CYC, 15000, low cycles after the last bit (300 us).

Ports:
- clk  in  1  system clock (50 MHz nominal).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request.
- busy  out  1  high from the cycle after an accepted start until the end of the latch period.
- done  out  1  one-cycle pulse when the latch period completes.
- mem_address  out  ADDR_W  RAM port-2 word address.
- mem_chipselect  out  1  RAM port-2 chipselect.
- mem_write  out  1  constant 0.
- mem_byteenable  out  4  constant 4'hF.
- mem_clken  out  1  constant 1.
- mem_readdata  in  32  RAM port-2 read data.
- led_dout  out  1  serial strip data.

Behaviour:
- Reset (asynchronous, immediate):
  - led_dout=0, busy=0, done=0, mem_chipselect=0, mem_address=BASE_ADDR.
  - FSM goes to IDLE and the LED index is cleared.
- RAM timing: the address is registered inside the RAM and readdata is unregistered. The address and chipselect driven in cycle N give valid mem_readdata in cycle N+1; the block captures it in N+1. mem_chipselect is high only in issue cycles.
- Word format:
  - [23:16]=R, [15:8]=G, [7:0]=B; [31:24] is ignored.
  - Wire order is G7..G0, R7..R0, B7..B0, MSB first: 24 bits per LED.
- FSM states: IDLE, FETCH, CAPTURE, SEND, LATCH.
  - IDLE: when start=1, set idx=0 and go to FETCH. busy rises on the next cycle.
  - FETCH (1 cycle): drive mem_address=BASE_ADDR+idx with chipselect=1, then go to CAPTURE.
  - CAPTURE (1 cycle): load the shift register with the reordered GRB word and go to SEND.
  - SEND: each bit lasts exactly BIT_CYC cycles. led_dout=1 for the first T1H_CYC cycles (bit=1) or T0H_CYC cycles (bit=0), then 0 for the rest.
  - SEND prefetch: in the first cycle of bit 23 (the last bit), if idx < NUM_LEDS-1, issue a read of idx+1 and capture it into the shadow register the next cycle.
  - End of SEND: after the last bit's final cycle, either load the shadow register and continue SEND with idx+1 and no gap cycles, or go to LATCH if idx == NUM_LEDS-1.
  - LATCH: led_dout=0 for LATCH_CYC cycles. On the last cycle, done=1 for one cycle and the FSM returns to IDLE; busy falls with done.
- Inter-frame gap: the only gap inside a frame is the 2-cycle FETCH/CAPTURE before LED 0. During this gap led_dout=0.
- start handling: start while busy (including the done cycle) is ignored and not queued. start in the cycle after done begins a new frame.
- Counter widths:
  - The bit-cycle counter is sized by $clog2(BIT_CYC).
  - The latch counter is sized by $clog2(LATCH_CYC).
  - idx is ADDR_W bits wide; address arithmetic is modulo 2^ADDR_W, but the parameter check forbids wrap.
- RAM writes through s1 during a frame are allowed; a word is sampled when it is fetched.

Optional Feature:
- Macro: WS2812_BRIGHTNESS_EN.
- When defined:
  - Adds an input port brightness [7:0], sampled once per frame on the accepted start.
  - Each 8-bit channel c becomes (c*(brightness+1))>>8, computed in CAPTURE and at the shadow load with a 16-bit intermediate product.
  - brightness=255 passes colours unchanged; 0 gives all channels at 0.
- When undefined: no port and no multiplier; colours pass unchanged.

Decomposition:
- Package ws2812_pkg:
  - state enum (IDLE, FETCH, CAPTURE, SEND, LATCH);
  - BITS_PER_LED=24;
  - function grb_reorder(word) returning 24 bits.
- Sub-module ws2812_bit_tx: shift register plus bit-cycle counter.
  - Inputs: load, data[23:0].
  - Outputs: dout, last_bit_first_cycle, word_done.
  - The top level holds the FSM, address generation and shadow register.

Test Plan:
- Single frame, 1 LED:
  - Stimulus: NUM_LEDS=1, word 0x00FF0000 (R=FF), start.
  - Expect 8 zero bits (20-cycle high), then 8 one bits (40-cycle high), then 8 zero bits, each bit 63 cycles.
  - Then 15000 low cycles, then a done pulse; busy high for exactly 2+24*63+15000 cycles.
- RAM read timing:
  - Stimulus: address/readdata model with 1-cycle latency.
  - Expect chipselect pulses only at FETCH and at the start of each bit 23.
  - With NUM_LEDS=3, BASE_ADDR=100, expect addresses 100, 101, 102 in order and no chipselect in LATCH.
- Seamless LED boundary:
  - Stimulus: NUM_LEDS=2, words 0x00000001 and 0x00800000.
  - Expect led_dout to rise exactly 63 cycles after the final bit of LED 0 began, with no extra low cycles.
- Start while busy:
  - Stimulus: pulse start mid-SEND and again on the done cycle.
  - Expect both ignored; start one cycle after done begins a new frame.
- Reset mid-frame:
  - Stimulus: drop reset_n during a high phase of led_dout.
  - Expect led_dout=0 and busy=0 asynchronously; after release the block is IDLE and a new start restarts from BASE_ADDR.
- Brightness (WS2812_BRIGHTNESS_EN):
  - Stimulus: brightness=127 with word 0x00C8FF10.
  - Expect G=0x7F, R=0x64, B=0x08 on the wire; brightness=0 yields 24 zero bits.
